// File: rtl/operand_issue_buffer_pkg.sv
// rtl/operand_issue_buffer_pkg.sv - shared types for the operand issue buffer
package operand_issue_buffer_pkg;
  localparam int DATA_W = 64;

  typedef logic [DATA_W-1:0] reg_data_t;

  typedef struct packed {
    logic      valid;
    reg_data_t data;
  } operand_t;

  typedef enum logic [2:0] {
    SLOT_EMPTY,
    SLOT_WAIT,
    SLOT_READY,
    SLOT_FIRED,
    SLOT_NULL
  } slot_state_e;

  localparam logic [1:0] PRED_ON_FALSE = 2'b10;
  localparam logic [1:0] PRED_ON_TRUE  = 2'b11;

  localparam logic [1:0] OPND_IDX_LEFT  = 2'd0;
  localparam logic [1:0] OPND_IDX_RIGHT = 2'd1;
  localparam logic [1:0] OPND_IDX_PRED  = 2'd2;

  // Encoding 01 behaves as unpredicated.
  function automatic logic pred_active(input logic [1:0] mode);
    return (mode == PRED_ON_FALSE) || (mode == PRED_ON_TRUE);
  endfunction
endpackage

// File: rtl/operand_issue_buffer_if.sv
// rtl/operand_issue_buffer_if.sv - instruction load, operand delivery and ALU issue bundle
interface operand_issue_buffer_if #(
  parameter int NUM_SLOTS = 8
) ();
  import operand_issue_buffer_pkg::*;
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  logic              inst_wr_en;
  logic [SLOT_W-1:0] inst_wr_slot;
  logic [7:0]        inst_wr_opcode;
  logic [2:0]        inst_wr_class;
  logic [19:0]       inst_wr_imm;
  logic [1:0]        inst_wr_bit;
  logic [1:0]        inst_wr_need;
  logic [1:0]        inst_wr_pred;

  logic              opnd_valid;
  logic [SLOT_W-1:0] opnd_slot;
  logic [1:0]        opnd_idx;
  reg_data_t         opnd_data;

  logic              issue_stall;

  logic [7:0]        alu_opcode;
  logic [2:0]        alu_class;
  logic [19:0]       alu_imm;
  logic [1:0]        alu_bit;
  operand_t [1:0]    alu_operands;
  logic              alu_fire;
  logic [SLOT_W-1:0] alu_slot;

  modport master (
    input  inst_wr_en, inst_wr_slot, inst_wr_opcode, inst_wr_class, inst_wr_imm,
           inst_wr_bit, inst_wr_need, inst_wr_pred,
           opnd_valid, opnd_slot, opnd_idx, opnd_data, issue_stall,
    output alu_opcode, alu_class, alu_imm, alu_bit, alu_operands, alu_fire, alu_slot
  );

  modport slave (
    output inst_wr_en, inst_wr_slot, inst_wr_opcode, inst_wr_class, inst_wr_imm,
           inst_wr_bit, inst_wr_need, inst_wr_pred,
           opnd_valid, opnd_slot, opnd_idx, opnd_data, issue_stall,
    input  alu_opcode, alu_class, alu_imm, alu_bit, alu_operands, alu_fire, alu_slot
  );
endinterface

// File: rtl/operand_issue_buffer_picker.sv
// rtl/operand_issue_buffer_picker.sv - lowest-index-first selector over slot ready bits
module slot_priority_picker #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     ready,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] index,
  output logic             any_ready
);
  always_comb begin
    onehot    = '0;
    index     = '0;
    any_ready = |ready;
    // Scanning downward lets the lowest ready index overwrite last.
    for (int i = N - 1; i >= 0; i--) begin
      if (ready[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        index     = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/operand_issue_buffer.sv
// rtl/operand_issue_buffer.sv - per-tile instruction window collecting operands and issuing to the ALU
module operand_issue_buffer
  import operand_issue_buffer_pkg::*;
#(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = $clog2(NUM_SLOTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  operand_issue_buffer_if.master bus,
  output logic [SLOT_W:0]        pending_cnt,
  output logic                   block_done,
  output logic                   err
);
  slot_state_e state_q [NUM_SLOTS];
  slot_state_e state_d [NUM_SLOTS];
  logic [7:0]  opc_q   [NUM_SLOTS];
  logic [2:0]  cls_q   [NUM_SLOTS];
  logic [19:0] imm_q   [NUM_SLOTS];
  logic [1:0]  bit_q   [NUM_SLOTS];
  logic [1:0]  need_q  [NUM_SLOTS];
  logic [1:0]  pmode_q [NUM_SLOTS];
  reg_data_t   left_q  [NUM_SLOTS];
  reg_data_t   right_q [NUM_SLOTS];

  logic [NUM_SLOTS-1:0] lp_q, rp_q, pp_q, lp_d, rp_d, pp_d;
  logic [NUM_SLOTS-1:0] load_hit, cap_l, cap_r, cap_p, ready, pick_oh;
  logic [SLOT_W-1:0]    pick_idx;
  logic                 any_ready, fire, err_set;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) ready[i] = (state_q[i] == SLOT_READY);
  end

  slot_priority_picker #(.N(NUM_SLOTS), .IDX_W(SLOT_W)) u_picker (
    .ready     (ready),
    .onehot    (pick_oh),
    .index     (pick_idx),
    .any_ready (any_ready)
  );

  assign fire = any_ready && !bus.issue_stall && !flush;

  // A load is applied before the operand check, so both may land on one edge.
  always_comb begin : next_state
    slot_state_e st;
    logic [1:0]  nd, pm;
    logic        lp, rp, pp;
    state_d  = state_q;
    lp_d     = lp_q;
    rp_d     = rp_q;
    pp_d     = pp_q;
    load_hit = '0;
    cap_l    = '0;
    cap_r    = '0;
    cap_p    = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      load_hit[i] = bus.inst_wr_en && (bus.inst_wr_slot == SLOT_W'(i)) && (state_q[i] == SLOT_EMPTY);
      st = load_hit[i] ? SLOT_WAIT : state_q[i];
      nd = load_hit[i] ? bus.inst_wr_need : need_q[i];
      pm = load_hit[i] ? bus.inst_wr_pred : pmode_q[i];
      lp = !load_hit[i] && lp_q[i];
      rp = !load_hit[i] && rp_q[i];
      pp = !load_hit[i] && pp_q[i];
      if (bus.opnd_valid && (bus.opnd_slot == SLOT_W'(i)) && (st == SLOT_WAIT)) begin
        case (bus.opnd_idx)
          OPND_IDX_LEFT:  cap_l[i] = nd[0] && !lp;
          OPND_IDX_RIGHT: cap_r[i] = nd[1] && !rp;
          OPND_IDX_PRED:  cap_p[i] = pred_active(pm) && !pp;
          default:        ;
        endcase
      end
      lp = lp | cap_l[i];
      rp = rp | cap_r[i];
      pp = pp | cap_p[i];
      if (st == SLOT_WAIT) begin
        if (cap_p[i] && (bus.opnd_data[0] != pm[0]))
          state_d[i] = SLOT_NULL;
        else if ((!nd[0] || lp) && (!nd[1] || rp) && (!pred_active(pm) || pp))
          state_d[i] = SLOT_READY;
        else
          state_d[i] = SLOT_WAIT;
      end else if ((st == SLOT_READY) && fire && pick_oh[i]) begin
        state_d[i] = SLOT_FIRED;
      end
      lp_d[i] = lp;
      rp_d[i] = rp;
      pp_d[i] = pp;
    end
    err_set = !flush &&
              ((bus.inst_wr_en && (state_q[bus.inst_wr_slot] != SLOT_EMPTY)) ||
               (bus.opnd_valid && !(|(cap_l | cap_r | cap_p))));
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < NUM_SLOTS; i++) state_q[i] <= SLOT_EMPTY;
      lp_q <= '0;
      rp_q <= '0;
      pp_q <= '0;
    end else begin
      state_q <= state_d;
      lp_q    <= lp_d;
      rp_q    <= rp_d;
      pp_q    <= pp_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

  // Payload is only observed once the slot state qualifies it, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (load_hit[i]) begin
        opc_q[i]   <= bus.inst_wr_opcode;
        cls_q[i]   <= bus.inst_wr_class;
        imm_q[i]   <= bus.inst_wr_imm;
        bit_q[i]   <= bus.inst_wr_bit;
        need_q[i]  <= bus.inst_wr_need;
        pmode_q[i] <= bus.inst_wr_pred;
      end
      if (cap_l[i]) left_q[i]  <= bus.opnd_data;
      if (cap_r[i]) right_q[i] <= bus.opnd_data;
    end
  end

  always_comb begin
    operand_t [1:0] ops;
    ops              = '0;
    bus.alu_opcode   = '0;
    bus.alu_class    = '0;
    bus.alu_imm      = '0;
    bus.alu_bit      = '0;
    bus.alu_slot     = '0;
    bus.alu_fire     = fire;
    if (fire) begin
      bus.alu_opcode = opc_q[pick_idx];
      bus.alu_class  = cls_q[pick_idx];
      bus.alu_imm    = imm_q[pick_idx];
      bus.alu_bit    = bit_q[pick_idx];
      bus.alu_slot   = pick_idx;
      ops[0].valid   = need_q[pick_idx][0];
      ops[0].data    = need_q[pick_idx][0] ? left_q[pick_idx] : '0;
      ops[1].valid   = need_q[pick_idx][1];
      ops[1].data    = need_q[pick_idx][1] ? right_q[pick_idx] : '0;
    end
    bus.alu_operands = ops;
  end

  always_comb begin
    logic loaded;
    pending_cnt = '0;
    loaded      = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if ((state_q[i] == SLOT_WAIT) || (state_q[i] == SLOT_READY))
        pending_cnt = pending_cnt + {{SLOT_W{1'b0}}, 1'b1};
      if (state_q[i] != SLOT_EMPTY) loaded = 1'b1;
    end
    block_done = loaded && (pending_cnt == '0);
  end
endmodule

// File: doc/operand_issue_buffer.md
# operand_issue_buffer

Per-E-tile instruction window that feeds `alu_fp_unit`. It holds up to NUM_SLOTS decoded instructions of the current block and collects left, right and predicate operands from the operand network. When an instruction is complete and its predicate is satisfied, it drives opcode, class, immediate and operands to the ALU and asserts fire. It sits between the tile's operand-network ingress and `alu_fp_unit`, and is the producing end of the ALU's operand/fire interface.

## Interface
- NUM_SLOTS, 8, instruction slots per tile (power of 2, ≥2)
- DATA_W, 64, operand data width (matches reg_data_t)
- SLOT_W, $clog2(NUM_SLOTS), slot index width (derived)

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high (already decided)
- flush  in  1  block commit/abort; clears every slot
- inst_wr_en  in  1  load one decoded instruction
- inst_wr_slot  in  SLOT_W  target slot
- inst_wr_opcode / inst_wr_class / inst_wr_imm / inst_wr_bit  in  8/3/20/2  decoded fields, stored verbatim
- inst_wr_need  in  2  bit0 = needs left, bit1 = needs right
- inst_wr_pred  in  2  00 = unpredicated, 10 = fire on false, 11 = fire on true (01 treated as 00)
- opnd_valid  in  1  operand delivery strobe
- opnd_slot  in  SLOT_W  destination slot
- opnd_idx  in  2  0 = left, 1 = right, 2 = predicate (3 is illegal)
- opnd_data  in  DATA_W  operand value; predicate uses bit 0
- issue_stall  in  1  downstream routing full; suppresses issue
- alu_opcode / alu_class / alu_imm / alu_bit  out  8/3/20/2  fields of the issuing slot
- alu_operands  out  operand_t[1:0]  {valid, data} left/right of the issuing slot
- alu_fire  out  1  issue strobe to `alu_fp_unit`
- alu_slot  out  SLOT_W  index of the issuing slot
- pending_cnt  out  SLOT_W+1  slots in WAIT or READY
- block_done  out  1  at least one slot loaded, none pending
- err  out  1  sticky protocol error

## Operation
- Each slot has a state: EMPTY, WAIT, READY, FIRED, NULL. It also stores fields, left/right data with present bits, and predicate present/value bits.
- inst_wr_en to an EMPTY slot: the slot enters WAIT, present bits clear, and it contributes to pending_cnt. inst_wr_en to a non-EMPTY slot is ignored and sets err.
- Operand to a slot in WAIT: data is captured and the present bit set. Delivery to EMPTY, FIRED or NULL, a duplicate operand, an unneeded operand, or opnd_idx = 3: dropped and err set. A predicate delivered to an unpredicated slot: dropped and err set.
- A predicate whose bit 0 mismatches the polarity moves the slot WAIT → NULL. A slot in NULL never fires and counts as complete.
- WAIT → READY when all needed operands are present and the predicate (if any) is present and matching.
- Issue: the lowest-index READY slot is selected. If issue_stall = 0, alu_fire = 1 and the slot moves READY → FIRED at the clock edge.
- alu_operands[i].valid = need[i]. Unneeded data is driven 0. All alu_* fields are 0 when alu_fire = 0.
- flush (or rst) puts every slot in EMPTY and clears pending_cnt and block_done. err is cleared by rst only.
- block_done = (any slot ≠ EMPTY) && pending_cnt == 0.

## Timing
- Reset values: alu_fire = 0, alu_* = 0, alu_slot = 0, pending_cnt = 0, block_done = 0, err = 0, all slots EMPTY.
- alu_* outputs are combinational from the registered slot state. No combinational path exists from opnd_* or inst_wr_* to alu_*.
- Latency: the last operand captured at edge N gives alu_fire high in cycle N→N+1. `alu_fp_unit`'s valid_out follows one edge later.
- A 0-operand unpredicated instruction written at edge N fires in cycle N→N+1.
- Simultaneous inst_wr and operand to the same slot: the load is applied first and the operand is captured in the same edge.
- flush wins over inst_wr, operand and issue in the same cycle. No fire is asserted in a flush cycle.
- issue_stall holds READY slots. Selection is re-evaluated every cycle, so a lower-index slot becoming READY pre-empts a stalled higher one.
- Throughput: at most one issue per cycle, one operand per cycle, and one load per cycle.

## Structure
- Shared package (trips_types): operand_t, reg_data_t, slot_state_e (EMPTY/WAIT/READY/FIRED/NULL), pred-mode encodings, OPND_IDX_* constants. Opcode/class constants stay in trips_isa.
- Sub-module: `slot_priority_picker`, a parameterised lowest-index-first one-hot/index encoder over NUM_SLOTS ready bits, with an any_ready output.

## Test plan
- Load slot 3 with ADD, need = 11, unpredicated; deliver left = 5 then right = 7. Expect alu_fire for exactly one cycle with alu_slot = 3 and operands 5/7, slot 3 → FIRED, pending_cnt = 0, block_done = 1.
- Load slot 1, pred = 11, need = 01; deliver left = 9, then predicate = 0. Expect no fire, slot → NULL, block_done = 1. Repeat with predicate = 1: fires one cycle after the predicate edge.
- Make slots 2 and 5 READY together with issue_stall = 1 for 3 cycles. Expect no fire during the stall. After release: slot 2 fires, then slot 5 the next cycle.
- Deliver an operand to an EMPTY slot and a duplicate left operand to a WAIT slot. Expect err = 1 (sticky across flush), state unchanged, no fire.
- In one cycle, load slot 0 and deliver its sole operand (need = 01). Expect fire the next cycle. Assert flush while slot 4 is READY: expect no fire, all slots EMPTY, pending_cnt = 0.
- Assert rst mid-block with 6 slots WAIT. Expect all outputs at reset values on the next cycle; a subsequent operand delivery to those slots sets err.
